// File: rtl/frame_seq_pkg.sv
// Shared state encodings, default timeout and index helper for frame_seq_ctrl.
package frame_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_CAP_REQ  = 3'd1;
    localparam state_t ST_CAP_ACK  = 3'd2;
    localparam state_t ST_FILT_REQ = 3'd3;
    localparam state_t ST_FILT_ACK = 3'd4;
    localparam state_t ST_SWAP     = 3'd5;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 2_000_000;

    // Next buffer in the rotation, modulo the number of buffers.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned num_bufs);
        return ((idx + 32'd1) >= num_bufs) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/frame_seq_ctrl_stage_handshake.sv
// req/done/ack engine with a watchdog for one pipeline stage (capture or filter).
module stage_handshake
    import frame_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_state_i,
    input  logic ack_state_i,
    input  logic done_i,
    output logic req_o,
    output logic ack_o,
    output logic accept_c_o,
    output logic timeout_c_o
);

    localparam int unsigned TO_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            req_q, req_d;
    logic            ack_q, ack_d;

    // done only counts once the partner has actually seen req high.
    assign accept_c_o  = req_state_i && req_q && done_i;
    assign timeout_c_o = req_state_i && req_q && !done_i && (cnt_q == TO_LAST);

    always_comb begin
        req_d = req_state_i && !timeout_c_o;
        ack_d = ack_state_i;
        cnt_d = '0;
        if (req_state_i && req_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            req_q <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            req_q <= req_d;
            ack_q <= ack_d;
        end
    end

    assign req_o = req_q;
    assign ack_o = ack_q;

endmodule

// File: rtl/frame_seq_ctrl.sv
// Frame-buffer rotation controller for the camera-to-VGA path.
// FRAME_SEQ_FILTER_EN adds the filter stage (FILT_REQ/FILT_ACK and filt_* handshake ports).
module frame_seq_ctrl
    import frame_seq_pkg::*;
#(
    parameter int unsigned NUM_BUFS       = 2,
    parameter int unsigned IDX_W          = 2,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             snap_i,
    output logic             cap_req_o,
    input  logic             cap_done_i,
    output logic             cap_ack_o,
`ifdef FRAME_SEQ_FILTER_EN
    output logic             filt_req_o,
    input  logic             filt_done_i,
    output logic             filt_ack_o,
`endif
    output logic [IDX_W-1:0] cap_idx_o,
    output logic [IDX_W-1:0] filt_src_idx_o,
    output logic [IDX_W-1:0] filt_dst_idx_o,
    output logic [IDX_W-1:0] disp_idx_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [2:0]       state_dbg_o
);

`ifdef FRAME_SEQ_FILTER_EN
    localparam int unsigned MIN_BUFS = 3;
`else
    localparam int unsigned MIN_BUFS = 2;
`endif

    if (NUM_BUFS < MIN_BUFS) begin : g_bad_num_bufs
        $error("frame_seq_ctrl: NUM_BUFS too small for this configuration");
    end
    if ((2 ** IDX_W) < NUM_BUFS) begin : g_bad_idx_w
        $error("frame_seq_ctrl: IDX_W cannot address NUM_BUFS buffers");
    end

    localparam logic [IDX_W-1:0] RST_CAP = IDX_W'(1);
    localparam logic [IDX_W-1:0] RST_DST = IDX_W'(wrap_inc(32'd1, NUM_BUFS));

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cap_idx_q, cap_idx_d;
    logic [IDX_W-1:0] dst_idx_q, dst_idx_d;
    logic [IDX_W-1:0] disp_idx_q, disp_idx_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [IDX_W-1:0] swap_src_c;

    logic cap_accept_c, cap_timeout_c;

    stage_handshake #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_cap_hs (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_state_i (state_q == ST_CAP_REQ),
        .ack_state_i (state_q == ST_CAP_ACK),
        .done_i      (cap_done_i),
        .req_o       (cap_req_o),
        .ack_o       (cap_ack_o),
        .accept_c_o  (cap_accept_c),
        .timeout_c_o (cap_timeout_c)
    );

`ifdef FRAME_SEQ_FILTER_EN
    logic filt_accept_c, filt_timeout_c;

    stage_handshake #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_filt_hs (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_state_i (state_q == ST_FILT_REQ),
        .ack_state_i (state_q == ST_FILT_ACK),
        .done_i      (filt_done_i),
        .req_o       (filt_req_o),
        .ack_o       (filt_ack_o),
        .accept_c_o  (filt_accept_c),
        .timeout_c_o (filt_timeout_c)
    );

    // The display takes the filtered buffer; capture resumes just past it.
    assign swap_src_c = dst_idx_q;
`else
    assign swap_src_c = cap_idx_q;
`endif

    always_comb begin
        state_d     = state_q;
        cap_idx_d   = cap_idx_q;
        dst_idx_d   = dst_idx_q;
        disp_idx_d  = disp_idx_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;
        busy_d      = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (run_i || snap_i) begin
                    state_d = ST_CAP_REQ;
                end
            end
            ST_CAP_REQ: begin
                if (cap_accept_c) begin
                    state_d = ST_CAP_ACK;
                end else if (cap_timeout_c) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_CAP_ACK: begin
`ifdef FRAME_SEQ_FILTER_EN
                state_d = ST_FILT_REQ;
`else
                state_d = ST_SWAP;
`endif
            end
`ifdef FRAME_SEQ_FILTER_EN
            ST_FILT_REQ: begin
                if (filt_accept_c) begin
                    state_d = ST_FILT_ACK;
                end else if (filt_timeout_c) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_FILT_ACK: begin
                state_d = ST_SWAP;
            end
`endif
            ST_SWAP: begin
                disp_idx_d  = swap_src_c;
                cap_idx_d   = IDX_W'(wrap_inc(32'(swap_src_c), NUM_BUFS));
                dst_idx_d   = IDX_W'(wrap_inc(wrap_inc(32'(swap_src_c), NUM_BUFS), NUM_BUFS));
                frame_cnt_d = frame_cnt_q + 1'b1;
                state_d     = run_i ? ST_CAP_REQ : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cap_idx_q   <= RST_CAP;
            dst_idx_q   <= RST_DST;
            disp_idx_q  <= '0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_idx_q   <= cap_idx_d;
            dst_idx_q   <= dst_idx_d;
            disp_idx_q  <= disp_idx_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign cap_idx_o      = cap_idx_q;
    assign filt_src_idx_o = cap_idx_q;
    assign filt_dst_idx_o = dst_idx_q;
    assign disp_idx_o     = disp_idx_q;
    assign frame_cnt_o    = frame_cnt_q;
    assign err_o          = err_q;
    assign busy_o         = busy_q;
    assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Directed self-checking bench for frame_seq_ctrl; follows FRAME_SEQ_FILTER_EN like the DUT.
module tb_frame_seq_ctrl;

`ifdef FRAME_SEQ_FILTER_EN
    localparam int unsigned NB      = 3;
    localparam int          RST_DST = 2;
    localparam int CAP_SEQ  [5] = '{1, 0, 2, 1, 0};
    localparam int DST_SEQ  [5] = '{2, 1, 0, 2, 1};
    localparam int DISP_SEQ [5] = '{2, 1, 0, 2, 1};
`else
    localparam int unsigned NB      = 2;
    localparam int          RST_DST = 0;
    localparam int CAP_SEQ  [5] = '{1, 0, 1, 0, 1};
    localparam int DISP_SEQ [5] = '{1, 0, 1, 0, 1};
`endif
    localparam int unsigned IW = 2;
    localparam int unsigned CW = 16;
    localparam int unsigned TO = 50;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          run      = 1'b0;
    logic          snap     = 1'b0;
    logic          cap_done = 1'b0;
    logic          cap_req, cap_ack;
`ifdef FRAME_SEQ_FILTER_EN
    logic          filt_done = 1'b0;
    logic          filt_req, filt_ack;
`endif
    logic [IW-1:0] cap_idx, filt_src, filt_dst, disp_idx;
    logic          busy, err;
    logic [CW-1:0] frame_cnt;
    logic [2:0]    state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    frame_seq_ctrl #(
        .NUM_BUFS       (NB),
        .IDX_W          (IW),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .run_i          (run),
        .snap_i         (snap),
        .cap_req_o      (cap_req),
        .cap_done_i     (cap_done),
        .cap_ack_o      (cap_ack),
`ifdef FRAME_SEQ_FILTER_EN
        .filt_req_o     (filt_req),
        .filt_done_i    (filt_done),
        .filt_ack_o     (filt_ack),
`endif
        .cap_idx_o      (cap_idx),
        .filt_src_idx_o (filt_src),
        .filt_dst_idx_o (filt_dst),
        .disp_idx_o     (disp_idx),
        .busy_o         (busy),
        .err_o          (err),
        .frame_cnt_o    (frame_cnt),
        .state_dbg_o    (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cap_req();
        int n = 0;
        while (cap_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cap_req_rise", 32'(cap_req), 32'd1);
    endtask

`ifdef FRAME_SEQ_FILTER_EN
    task automatic wait_filt_req();
        int n = 0;
        while (filt_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("filt_req_rise", 32'(filt_req), 32'd1);
    endtask
`endif

    // One full frame: index checks at request, exact done->ack timing, display update at the end.
    task automatic serve_frame(input int f, input bit snap_busy, input bit drop_run);
        wait_cap_req();
        check("cap_idx", 32'(cap_idx), 32'(CAP_SEQ[f]));
        check("filt_src_idx", 32'(filt_src), 32'(CAP_SEQ[f]));
        check("busy_in_frame", 32'(busy), 32'd1);
        if (drop_run) run = 1'b0;
        if (snap_busy) begin
            snap = 1'b1;
            tick(1);
            snap = 1'b0;
            tick(2);
            snap = 1'b1;
            tick(1);
            snap = 1'b0;
        end
        tick(10);
        cap_done = 1'b1;
        tick(1);
        check("cap_ack_early", 32'(cap_ack), 32'd0);
        check("cap_req_hold", 32'(cap_req), 32'd1);
        tick(1);
        check("cap_ack_high", 32'(cap_ack), 32'd1);
        check("cap_req_drop", 32'(cap_req), 32'd0);
        cap_done = 1'b0;
        tick(1);
        check("cap_ack_one_cycle", 32'(cap_ack), 32'd0);
`ifdef FRAME_SEQ_FILTER_EN
        wait_filt_req();
        check("filt_dst_idx", 32'(filt_dst), 32'(DST_SEQ[f]));
        check("filt_src_during_filt", 32'(filt_src), 32'(CAP_SEQ[f]));
        tick(5);
        filt_done = 1'b1;
        tick(1);
        check("filt_ack_early", 32'(filt_ack), 32'd0);
        tick(1);
        check("filt_ack_high", 32'(filt_ack), 32'd1);
        check("filt_req_drop", 32'(filt_req), 32'd0);
        filt_done = 1'b0;
        tick(1);
        check("filt_ack_one_cycle", 32'(filt_ack), 32'd0);
`endif
        check("disp_idx", 32'(disp_idx), 32'(DISP_SEQ[f]));
        check("frame_cnt", 32'(frame_cnt), 32'(f + 1));
    endtask

    // Display must never point at a buffer that is being written.
    always @(negedge clk) begin
        if (!rst) begin
            n_tests++;
            assert (disp_idx !== cap_idx) else begin
                n_fail++;
                $error("FAIL inv_disp_vs_cap: observed disp=%0d cap=%0d required different", disp_idx, cap_idx);
            end
`ifdef FRAME_SEQ_FILTER_EN
            if (filt_req) begin
                n_tests++;
                assert (disp_idx !== filt_dst) else begin
                    n_fail++;
                    $error("FAIL inv_disp_vs_dst: observed disp=%0d dst=%0d required different", disp_idx, filt_dst);
                end
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(3);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_cap_req", 32'(cap_req), 32'd0);
        check("rst_cap_ack", 32'(cap_ack), 32'd0);
        check("rst_disp_idx", 32'(disp_idx), 32'd0);
        check("rst_cap_idx", 32'(cap_idx), 32'd1);
        check("rst_filt_dst", 32'(filt_dst), 32'(RST_DST));
        check("rst_err", 32'(err), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(3);
        check("idle_hold", 32'(state_dbg), 32'd0);

        // Continuous run; run drops during the third frame, which still completes.
        run = 1'b1;
        serve_frame(0, 1'b0, 1'b0);
        serve_frame(1, 1'b0, 1'b0);
        serve_frame(2, 1'b0, 1'b1);
        tick(3);
        check("run_stop_state", 32'(state_dbg), 32'd0);
        check("run_stop_busy", 32'(busy), 32'd0);
        check("run_stop_cnt", 32'(frame_cnt), 32'd3);
        check("run_stop_cap_idx", 32'(cap_idx), 32'(CAP_SEQ[3]));

        // Stray done while idle is ignored.
        cap_done = 1'b1;
        tick(2);
        cap_done = 1'b0;
        tick(2);
        check("stray_done_state", 32'(state_dbg), 32'd0);
        check("stray_done_ack", 32'(cap_ack), 32'd0);
        check("stray_done_cnt", 32'(frame_cnt), 32'd3);

        // Single shot with snaps pulsed while busy.
        snap = 1'b1;
        tick(1);
        snap = 1'b0;
        serve_frame(3, 1'b1, 1'b0);
        tick(30);
        check("snap_state", 32'(state_dbg), 32'd0);
        check("snap_cnt", 32'(frame_cnt), 32'd4);
        check("snap_no_req", 32'(cap_req), 32'd0);

        // Capture timeout: done never arrives.
        snap = 1'b1;
        tick(1);
        snap = 1'b0;
        wait_cap_req();
        tick(TO - 1);
        check("to_req_before", 32'(cap_req), 32'd1);
        check("to_err_before", 32'(err), 32'd0);
        tick(1);
        check("to_err_set", 32'(err), 32'd1);
        check("to_req_drop", 32'(cap_req), 32'd0);
        check("to_state_idle", 32'(state_dbg), 32'd0);
        check("to_cap_idx", 32'(cap_idx), 32'(CAP_SEQ[4]));
        check("to_disp_idx", 32'(disp_idx), 32'(DISP_SEQ[3]));
        check("to_frame_cnt", 32'(frame_cnt), 32'd4);
        tick(20);
        check("to_err_sticky", 32'(err), 32'd1);
        check("to_busy_low", 32'(busy), 32'd0);

        // A normal frame after timeout keeps err set.
        snap = 1'b1;
        tick(1);
        snap = 1'b0;
        serve_frame(4, 1'b0, 1'b0);
        check("err_sticky_frame", 32'(err), 32'd1);

        // Reset in the middle of a stage.
        run = 1'b1;
        wait_cap_req();
`ifdef FRAME_SEQ_FILTER_EN
        cap_done = 1'b1;
        tick(2);
        cap_done = 1'b0;
        wait_filt_req();
`endif
        rst = 1'b1;
        tick(1);
`ifdef FRAME_SEQ_FILTER_EN
        check("mid_rst_filt_req", 32'(filt_req), 32'd0);
`endif
        check("mid_rst_cap_req", 32'(cap_req), 32'd0);
        check("mid_rst_disp", 32'(disp_idx), 32'd0);
        check("mid_rst_cap_idx", 32'(cap_idx), 32'd1);
        check("mid_rst_cnt", 32'(frame_cnt), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'd0);
        run = 1'b0;
        rst = 1'b0;
        tick(3);
        check("post_rst_idle", 32'(state_dbg), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
